intc: RTL and testbench

INTC -- requirements
Module: intc

---
 rtl/intc.sv | 205 ++++++++++++++++++++
 tb/tb_intc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intc.sv
// Interrupt controller: up to 8 active-low asynchronous sources, per-source
// enable and edge/level selection, round-robin arbitration, and a
// claim/complete handshake that raises a single active-low request line.
module intc #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            ei
);

    typedef enum logic {
        IDLE    = 1'b0,
        CLAIMED = 1'b1
    } state_t;

    // The synchronizers carry the active-high form of the sources, so their
    // reset value of zero means "not asserted".
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;
    logic [NSRC-1:0] act_prev_q;
    logic [NSRC-1:0] s_act;

    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] edge_q;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] pending_d;
    logic [NSRC-1:0] excl;
    logic [NSRC-1:0] elig;

    logic [2:0]      arb_id;
    logic            arb_vld;
    logic [2:0]      win_id_q;
    logic            win_vld_q;

    state_t          state_q;
    logic [2:0]      cl_id_q;
    logic [2:0]      last_id_q;

    logic [31:0]     rdata_q;
    logic [31:0]     rdata_d;
    logic            ei_q;
    logic            ei_d;

    logic            rd_en;
    logic            wr_en;
    logic            claim_fire;
    logic            complete_fire;
    logic [3:0]      claim_val;
    logic            unused_wdata;

    assign rd_en = !sel && we;
    assign wr_en = !sel && !we;
    assign s_act = sync2_q;

    // Upper write-data bits only matter for wider registers that do not exist.
    assign unused_wdata = ^wdata[31:4];

    assign claim_fire    = rd_en && (addr == 2'd3) && (state_q == IDLE) && win_vld_q;
    assign complete_fire = wr_en && (addr == 2'd3) && (state_q == CLAIMED) &&
                           (wdata[3:0] == ({1'b0, cl_id_q} + 4'd1));
    assign claim_val     = (state_q == IDLE && win_vld_q) ? ({1'b0, win_id_q} + 4'd1) : 4'd0;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            act_prev_q <= '0;
        end else begin
            sync1_q    <= ~src;
            sync2_q    <= sync1_q;
            act_prev_q <= sync2_q;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q <= '0;
            edge_q   <= '0;
        end else if (wr_en) begin
            if (addr == 2'd0) enable_q <= wdata[NSRC-1:0];
            if (addr == 2'd2) edge_q   <= wdata[NSRC-1:0];
        end
    end

    // Pending next-state: edge sources latch a rising activity and clear on
    // claim (a coincident new edge wins); level sources follow activity.
    // Flipping a source's mode drops whatever it had pending.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NSRC; i++) begin
            if (edge_q[i]) begin
                pending_d[i] = (pending_q[i] &
                                ~(claim_fire && (win_id_q == 3'(i)))) |
                               (s_act[i] & ~act_prev_q[i]);
            end else begin
                pending_d[i] = s_act[i];
            end
            if (wr_en && (addr == 2'd2) && (wdata[i] != edge_q[i])) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    // Eligibility, with the outstanding claim masked out while it is held.
    always_comb begin
        excl = '0;
        for (int i = 0; i < NSRC; i++) begin
            excl[i] = (state_q == CLAIMED) && (cl_id_q == 3'(i));
        end
        elig = pending_q & enable_q & ~excl;
    end

    // Round-robin search starting just after the last claimed id.
    always_comb begin
        arb_vld = 1'b0;
        arb_id  = '0;
        for (int k = 0; k < NSRC; k++) begin
            for (int j = 0; j < NSRC; j++) begin
                if (!arb_vld && elig[j] && (j == (int'(last_id_q) + 1 + k) % NSRC)) begin
                    arb_vld = 1'b1;
                    arb_id  = 3'(j);
                end
            end
        end
    end

    // Register the arbitration winner every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_id_q  <= '0;
            win_vld_q <= 1'b0;
        end else begin
            win_id_q  <= arb_id;
            win_vld_q <= arb_vld;
        end
    end

    // Claim/complete state machine with claimed id and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cl_id_q   <= '0;
            last_id_q <= 3'(NSRC - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (claim_fire) begin
                        state_q   <= CLAIMED;
                        cl_id_q   <= win_id_q;
                        last_id_q <= win_id_q;
                    end
                end
                CLAIMED: begin
                    if (complete_fire) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read-data and request-line next values; the claiming read itself
    // already drops the request so it never lingers into CLAIMED.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                2'd0:    rdata_d = 32'(enable_q);
                2'd1:    rdata_d = 32'(pending_q);
                2'd2:    rdata_d = 32'(edge_q);
                default: rdata_d = 32'(claim_val);
            endcase
        end
        ei_d = !(win_vld_q && (state_q == IDLE) && !claim_fire);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            ei_q    <= 1'b1;
        end else begin
            rdata_q <= rdata_d;
            ei_q    <= ei_d;
        end
    end

    assign rdata = rdata_q;
    assign ei    = ei_q;

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: register table vectors plus claim/complete
// sequences for edge, level, round-robin, collision and reset cases.
module tb_intc;

    localparam int NSRC = 8;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic [NSRC-1:0] src   = '1;
    logic            sel   = 1'b1;
    logic            we    = 1'b1;
    logic [1:0]      addr  = 2'd0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic            ei;

    int n_cmp = 0;
    int n_bad = 0;

    intc #(.NSRC(NSRC)) dut (
        .clk   (clk),
        .rst   (rst),
        .src   (src),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ei    (ei)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b0; we = 1'b0; addr = a; wdata = d;
        cyc();
        sel = 1'b1; we = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b0; we = 1'b1; addr = a;
        cyc();
        sel = 1'b1;
        d = rdata;
    endtask

    task automatic wait_ei(input string name, input logic exp, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (ei === exp) break;
            cyc();
        end
        check(name, {31'b0, ei}, {31'b0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[14];
        logic [31:0] r;
        int          lat;
        int          low_cnt;
        int          rr_exp[4];

        // Reset state, checked asynchronously before any clock edge matters.
        #1 rst = 1'b0;
        #2;
        check("reset_rdata", rdata, 32'h0);
        check("reset_ei", {31'b0, ei}, 32'h1);
        cyc();
        cyc();
        rst = 1'b1;

        // Register access table.
        vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 2'd1, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 2'd0, 32'h000000A5, 32'h0};
        vecs[5]  = '{1'b0, 2'd0, 32'h0,        32'h000000A5};
        vecs[6]  = '{1'b1, 2'd2, 32'hFFFFFF3C, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,        32'h0000003C};
        vecs[8]  = '{1'b1, 2'd1, 32'h000000FF, 32'h0};
        vecs[9]  = '{1'b0, 2'd1, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 2'd0, 32'hFFFFFFFF, 32'h0};
        vecs[11] = '{1'b0, 2'd0, 32'h0,        32'h000000FF};
        vecs[12] = '{1'b1, 2'd3, 32'h00000001, 32'h0};
        vecs[13] = '{1'b0, 2'd3, 32'h0,        32'h0};
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                bus_wr(vecs[i].a, vecs[i].d);
            end else begin
                bus_rd(vecs[i].a, r);
                check($sformatf("vec%0d_rd_a%0d", i, vecs[i].a), r, vecs[i].exp);
            end
        end
        check("tbl_ei_idle", {31'b0, ei}, 32'h1);
        do_reset();

        // Level source 0: latency, claim, re-request after complete.
        bus_wr(2'd0, 32'h01);
        src[0] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 5; n++) begin
            cyc();
            if (lat < 0 && ei === 1'b0) lat = n;
        end
        check("latency_le5", {31'b0, (lat >= 1 && lat <= 5)}, 32'h1);
        bus_rd(2'd3, r);
        check("l0_claim", r, 32'h1);
        check("l0_ei_after_claim", {31'b0, ei}, 32'h1);
        bus_wr(2'd3, 32'h1);
        wait_ei("l0_ei_rerequest", 1'b0, 8);

        // Wrong completion id and claim while claimed.
        bus_rd(2'd3, r);
        check("l0_claim2", r, 32'h1);
        bus_wr(2'd3, 32'h5);
        cyc(); cyc(); cyc();
        check("bad_complete_ei", {31'b0, ei}, 32'h1);
        bus_rd(2'd3, r);
        check("claim_while_claimed", r, 32'h0);

        // Disabling the claimed source leaves the claim outstanding.
        bus_wr(2'd0, 32'h0);
        bus_rd(2'd3, r);
        check("disabled_still_claimed", r, 32'h0);
        bus_wr(2'd3, 32'h1);
        cyc(); cyc(); cyc(); cyc();
        check("disabled_ei_high", {31'b0, ei}, 32'h1);
        bus_wr(2'd0, 32'h01);
        wait_ei("reenable_ei", 1'b0, 8);
        src[0] = 1'b1;
        do_reset();

        // Two simultaneous edge pulses.
        bus_wr(2'd2, 32'hFF);
        bus_wr(2'd0, 32'hFF);
        src[2] = 1'b0; src[5] = 1'b0;
        cyc(); cyc();
        src = '1;
        wait_ei("edge_ei1", 1'b0, 8);
        bus_rd(2'd3, r);
        check("edge_claim1", r, 32'h3);
        bus_wr(2'd3, 32'h3);
        wait_ei("edge_ei2", 1'b0, 8);
        bus_rd(2'd3, r);
        check("edge_claim2", r, 32'h6);
        bus_wr(2'd3, 32'h6);
        cyc(); cyc(); cyc(); cyc();
        check("edge_ei_idle", {31'b0, ei}, 32'h1);
        bus_rd(2'd3, r);
        check("edge_claim3", r, 32'h0);
        do_reset();

        // Level round-robin fairness between sources 1 and 3.
        bus_wr(2'd0, 32'h0A);
        src[1] = 1'b0; src[3] = 1'b0;
        rr_exp = '{2, 4, 2, 4};
        for (int k = 0; k < 4; k++) begin
            wait_ei($sformatf("rr_ei%0d", k), 1'b0, 8);
            bus_rd(2'd3, r);
            check($sformatf("rr_claim%0d", k), r, 32'(rr_exp[k]));
            bus_wr(2'd3, 32'(rr_exp[k]));
        end
        bus_rd(2'd1, r);
        check("level_pending", r, 32'h0A);
        src = '1;
        do_reset();

        // New edge on source 4 coinciding with its claim.
        bus_wr(2'd2, 32'hFF);
        bus_wr(2'd0, 32'hFF);
        src[4] = 1'b0;
        cyc(); cyc();
        src[4] = 1'b1;
        wait_ei("coll_ei1", 1'b0, 8);
        cyc(); cyc(); cyc();
        src[4] = 1'b0;
        cyc(); cyc();
        bus_rd(2'd3, r);
        check("coll_claim1", r, 32'h5);
        src[4] = 1'b1;
        bus_rd(2'd1, r);
        check("coll_pending", r, 32'h10);
        check("coll_ei_claimed", {31'b0, ei}, 32'h1);
        bus_wr(2'd3, 32'h5);
        wait_ei("coll_ei2", 1'b0, 8);
        bus_rd(2'd3, r);
        check("coll_claim2", r, 32'h5);
        bus_wr(2'd3, 32'h5);
        do_reset();

        // Reset while a claim is outstanding and the source is held.
        bus_wr(2'd0, 32'h01);
        src[0] = 1'b0;
        wait_ei("rst_pre_ei", 1'b0, 8);
        bus_rd(2'd3, r);
        check("rst_pre_claim", r, 32'h1);
        rst = 1'b0;
        #2;
        check("rst_async_rdata", rdata, 32'h0);
        check("rst_async_ei", {31'b0, ei}, 32'h1);
        cyc();
        rst = 1'b1;
        bus_rd(2'd1, r);
        check("rst_pending", r, 32'h0);
        bus_rd(2'd0, r);
        check("rst_enable", r, 32'h0);
        bus_rd(2'd2, r);
        check("rst_edge", r, 32'h0);
        low_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (ei !== 1'b1) low_cnt++;
        end
        check("rst_ei_stays_high", 32'(low_cnt), 32'h0);
        bus_wr(2'd0, 32'h01);
        wait_ei("rst_post_ei", 1'b0, 8);
        bus_rd(2'd3, r);
        check("rst_post_claim", r, 32'h1);
        src = '1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
